// File: rtl/aq_mmu_tlb_sram_pkg.sv
// Shared constants and state encoding for the MMU TLB SRAM controller.
// Build option: AQ_MMU_TLB_SRAM_PAR_EN reserves the top entry bit for even parity.
package aq_mmu_tlb_sram_pkg;

  localparam int AW        = 6;
  localparam int DW        = 98;
  localparam int ENTRY_NUM = 64;
  localparam int PAR_BIT   = DW - 1;

  typedef enum logic {
    ST_FLUSH = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

endpackage

// File: rtl/aq_mmu_tlb_sram_ctrl_if.sv
// Request/response bundle between the MMU TLB logic (master) and the SRAM controller (slave).
// Build option: AQ_MMU_TLB_SRAM_PAR_EN changes the meaning of rd_data[DW-1] and rd_par_err.
interface aq_mmu_tlb_sram_ctrl_if;
  import aq_mmu_tlb_sram_pkg::*;

  logic          flush_req;
  logic          flush_busy;
  logic          flush_done;
  logic          wr_req;
  logic [AW-1:0] wr_idx;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] wr_mask;
  logic          wr_ack;
  logic          rd_req;
  logic [AW-1:0] rd_idx;
  logic          rd_ack;
  logic          rd_vld;
  logic [DW-1:0] rd_data;
  logic          rd_par_err;

  modport master (
    output flush_req, wr_req, wr_idx, wr_data, wr_mask, rd_req, rd_idx,
    input  flush_busy, flush_done, wr_ack, rd_ack, rd_vld, rd_data, rd_par_err
  );

  modport slave (
    input  flush_req, wr_req, wr_idx, wr_data, wr_mask, rd_req, rd_idx,
    output flush_busy, flush_done, wr_ack, rd_ack, rd_vld, rd_data, rd_par_err
  );

endinterface

// File: rtl/aq_mmu_tlb_sram_par.sv
// Combinational even-parity generate (write side) and check (read side) for TLB entries.
// Only instantiated when AQ_MMU_TLB_SRAM_PAR_EN is defined.
module aq_mmu_tlb_sram_par
  import aq_mmu_tlb_sram_pkg::*;
(
  input  logic [DW-2:0] wdata_i,
  output logic [DW-1:0] wdata_o,
  input  logic [DW-1:0] rdata_i,
  output logic          par_err_o
);

  // The parity bit makes the XOR of the whole word zero, so an all-zero flush word is consistent.
  assign wdata_o   = {^wdata_i, wdata_i};
  assign par_err_o = ^rdata_i;

endmodule

// File: rtl/aq_mmu_tlb_sram_ctrl.sv
// Sequencer/arbiter for the single-port 64 x 98 TLB SRAM: flush engine > refill write > lookup read.
// A full-array invalidate runs after every reset and on every flush request.
// Build option: AQ_MMU_TLB_SRAM_PAR_EN enables even parity in bit DW-1 (full-word writes only).
module aq_mmu_tlb_sram_ctrl #(
  parameter int ADDR_WIDTH = aq_mmu_tlb_sram_pkg::AW,
  parameter int DATA_WIDTH = aq_mmu_tlb_sram_pkg::DW,
  parameter int ENTRY_NUM  = aq_mmu_tlb_sram_pkg::ENTRY_NUM
) (
  input  logic                        forever_cpuclk,
  input  logic                        cpurst_b,
  aq_mmu_tlb_sram_ctrl_if.slave       bus,
  output logic                        sram_cen,
  output logic                        sram_gwen,
  output logic [ADDR_WIDTH-1:0]       sram_a,
  output logic [DATA_WIDTH-1:0]       sram_d,
  output logic [DATA_WIDTH-1:0]       sram_wen,
  input  logic [DATA_WIDTH-1:0]       sram_q
);
  import aq_mmu_tlb_sram_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(ENTRY_NUM - 1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    flush_done_q, flush_done_d;
  logic                    rd_vld_q, rd_vld_d;
  logic                    wr_ack_c, rd_ack_c;
  logic [DATA_WIDTH-1:0]   wr_word;
  logic [DATA_WIDTH-1:0]   wr_wen;

`ifdef AQ_MMU_TLB_SRAM_PAR_EN
  logic                    par_err;
  logic                    unused_mask;

  aq_mmu_tlb_sram_par u_par (
    .wdata_i   (bus.wr_data[DATA_WIDTH-2:0]),
    .wdata_o   (wr_word),
    .rdata_i   (sram_q),
    .par_err_o (par_err)
  );

  // Parity covers the whole word, so refills are always full-word and the mask is not used.
  assign unused_mask    = ^bus.wr_mask;
  assign wr_wen         = '0;
  assign bus.rd_data    = {1'b0, sram_q[DATA_WIDTH-2:0]};
  assign bus.rd_par_err = rd_vld_q & par_err;
`else
  assign wr_word        = bus.wr_data;
  assign wr_wen         = ~bus.wr_mask;
  assign bus.rd_data    = sram_q;
  assign bus.rd_par_err = 1'b0;
`endif

  assign bus.flush_busy = (state_q == ST_FLUSH);
  assign bus.flush_done = flush_done_q;
  assign bus.rd_vld     = rd_vld_q;
  assign bus.wr_ack     = wr_ack_c;
  assign bus.rd_ack     = rd_ack_c;

  // State register: reset restarts the invalidate pass and drops any pending read return.
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      state_q      <= ST_FLUSH;
      cnt_q        <= '0;
      flush_done_q <= 1'b0;
      rd_vld_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flush_done_q <= flush_done_d;
      rd_vld_q     <= rd_vld_d;
    end
  end

  // Next state: a flush request always restarts the pass; the last flush write arms flush_done.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    flush_done_d = 1'b0;
    rd_vld_d     = rd_ack_c;
    if (bus.flush_req) begin
      state_d = ST_FLUSH;
      cnt_d   = '0;
    end else if (state_q == ST_FLUSH) begin
      if (cnt_q == LAST_IDX) begin
        state_d      = ST_IDLE;
        cnt_d        = '0;
        flush_done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Output mux: one SRAM access per cycle; the flush_req cycle itself makes no access.
  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_a    = '0;
    sram_d    = '0;
    sram_wen  = '1;
    wr_ack_c  = 1'b0;
    rd_ack_c  = 1'b0;
    if (cpurst_b && !bus.flush_req) begin
      if (state_q == ST_FLUSH) begin
        sram_cen  = 1'b0;
        sram_gwen = 1'b0;
        sram_a    = cnt_q;
        sram_wen  = '0;
      end else if (bus.wr_req) begin
        sram_cen  = 1'b0;
        sram_gwen = 1'b0;
        sram_a    = bus.wr_idx;
        sram_d    = wr_word;
        sram_wen  = wr_wen;
        wr_ack_c  = 1'b1;
      end else if (bus.rd_req) begin
        sram_cen  = 1'b0;
        sram_a    = bus.rd_idx;
        rd_ack_c  = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aq_mmu_tlb_sram_ctrl.sv
// Self-checking bench for aq_mmu_tlb_sram_ctrl: behavioural SRAM, per-cycle reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_aq_mmu_tlb_sram_ctrl;
  import aq_mmu_tlb_sram_pkg::*;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  aq_mmu_tlb_sram_ctrl_if bus();

  logic          sram_cen, sram_gwen;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_d, sram_wen, sram_q, q_reg, corrupt;
  logic [DW-1:0] smem [ENTRY_NUM];

  aq_mmu_tlb_sram_ctrl dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_b),
    .bus            (bus),
    .sram_cen       (sram_cen),
    .sram_gwen      (sram_gwen),
    .sram_a         (sram_a),
    .sram_d         (sram_d),
    .sram_wen       (sram_wen),
    .sram_q         (sram_q)
  );

  // Behavioural single-port SRAM with registered read data and active-low bit write enables.
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen) smem[sram_a] <= (smem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            q_reg <= smem[sram_a];
    end
  end
  assign sram_q = q_reg ^ corrupt;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tmo(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting (t=%0t)", nm, $time);
  endtask

  function automatic logic [DW-1:0] rnd98();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] par_word(input logic [DW-1:0] d);
    logic [DW-1:0] w;
    w = d;
    w[DW-1] = ^d[DW-2:0];
    return w;
  endfunction

  // ---------------- reference model ----------------
  bit            m_valid = 1'b0;
  bit            m_fl, m_done, m_rdv;
  int            m_pos;
  logic [DW-1:0] m_rdq;
  logic [DW-1:0] mmem [ENTRY_NUM];

  // Compare every cycle at the falling edge, then advance the model to the next rising edge.
  always @(negedge clk) begin : sb
    logic          e_cen, e_gwen, e_wa, e_ra, e_err;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_d, e_wen, e_rd;
    e_cen = 1'b1; e_gwen = 1'b1; e_wa = 1'b0; e_ra = 1'b0;
    e_a = '0; e_d = '0; e_wen = '1; e_rd = '0; e_err = 1'b0;
    if (rst_b && !bus.flush_req) begin
      if (m_fl) begin
        e_cen = 1'b0; e_gwen = 1'b0; e_a = AW'(m_pos); e_d = '0; e_wen = '0;
      end else if (bus.wr_req) begin
        e_cen = 1'b0; e_gwen = 1'b0; e_a = bus.wr_idx; e_wa = 1'b1;
`ifdef AQ_MMU_TLB_SRAM_PAR_EN
        e_d = par_word(bus.wr_data); e_wen = '0;
`else
        e_d = bus.wr_data; e_wen = ~bus.wr_mask;
`endif
      end else if (bus.rd_req) begin
        e_cen = 1'b0; e_a = bus.rd_idx; e_ra = 1'b1;
      end
    end
    if (m_valid) begin
      chk("sram_cen", sram_cen, e_cen);
      chk("wr_ack", bus.wr_ack, e_wa);
      chk("rd_ack", bus.rd_ack, e_ra);
      if (!e_cen) begin
        chk("sram_gwen", sram_gwen, e_gwen);
        chk("sram_a", sram_a, e_a);
        if (!e_gwen) begin
          chk("sram_d", sram_d, e_d);
          chk("sram_wen", sram_wen, e_wen);
        end
      end else if (!rst_b) begin
        chk("sram_gwen_rst", sram_gwen, 1'b1);
      end
      chk("flush_busy", bus.flush_busy, m_fl);
      chk("flush_done", bus.flush_done, m_done);
      chk("rd_vld", bus.rd_vld, m_rdv);
      if (m_rdv) begin
        e_rd = m_rdq ^ corrupt;
`ifdef AQ_MMU_TLB_SRAM_PAR_EN
        e_err = ^e_rd;
        e_rd[DW-1] = 1'b0;
`endif
        chk("rd_data", bus.rd_data, e_rd);
        chk("rd_par_err", bus.rd_par_err, e_err);
      end
    end
    if (!rst_b) begin
      m_valid = 1'b1; m_fl = 1'b1; m_pos = 0; m_done = 1'b0; m_rdv = 1'b0;
    end else if (m_valid) begin
      m_rdv = e_ra;
      if (e_ra) m_rdq = mmem[bus.rd_idx];
      m_done = 1'b0;
      if (bus.flush_req) begin
        m_fl = 1'b1; m_pos = 0;
      end else if (m_fl) begin
        mmem[m_pos] = '0;
        if (m_pos == ENTRY_NUM - 1) begin
          m_fl = 1'b0; m_pos = 0; m_done = 1'b1;
        end else begin
          m_pos++;
        end
      end else if (e_wa) begin
`ifdef AQ_MMU_TLB_SRAM_PAR_EN
        mmem[bus.wr_idx] = par_word(bus.wr_data);
`else
        mmem[bus.wr_idx] = (mmem[bus.wr_idx] & ~bus.wr_mask) | (bus.wr_data & bus.wr_mask);
`endif
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input bit is_wr, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (is_wr ? bus.wr_ack : bus.rd_ack) ok = 1'b1;
      else step();
    end
    if (!ok) tmo(is_wr ? "wr_ack_wait" : "rd_ack_wait");
  endtask

  task automatic do_write(input logic [AW-1:0] idx, input logic [DW-1:0] d, input logic [DW-1:0] m);
    bit ok;
    bus.wr_req = 1'b1; bus.wr_idx = idx; bus.wr_data = d; bus.wr_mask = m;
    wait_ack(1'b1, ok);
    step();
    bus.wr_req = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] idx, output logic [DW-1:0] d, output logic err);
    bit ok;
    bus.rd_req = 1'b1; bus.rd_idx = idx;
    wait_ack(1'b0, ok);
    step();
    bus.rd_req = 1'b0;
    @(negedge clk);
    chk("rd_vld_after_ack", bus.rd_vld, 1'b1);
    d = bus.rd_data;
    err = bus.rd_par_err;
    step();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [DW-1:0] rdat;
    logic          rerr, wa, ra;
    bit            got, ok;
    int            cyc, first, dones;

    corrupt = '0;
    q_reg = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      smem[i] = rnd98();
      mmem[i] = '0;
    end
    bus.flush_req = 1'b0; bus.wr_req = 1'b0; bus.rd_req = 1'b0;
    bus.wr_idx = '0; bus.rd_idx = '0; bus.wr_data = '0; bus.wr_mask = '0;

    // Reset, then the automatic invalidate: done pulse in cycle 65 after release.
    repeat (5) @(posedge clk);
    #1 rst_b = 1'b1;
    cyc = 0; got = 1'b0;
    while (cyc < 100 && !got) begin
      @(negedge clk);
      cyc++;
      if (bus.flush_done) got = 1'b1;
    end
    if (!got) tmo("first_flush_done");
    else begin
      chk("first_done_cycle", cyc, 65);
      chk("busy_at_done", bus.flush_busy, 1'b0);
    end
    repeat (6) step();

    // Refill then lookup of the same entry.
    do_write(6'd5, 98'h3_FFFF_FFFF, '1);
    do_read(6'd5, rdat, rerr);
    chk("rd5_data", rdat, 98'h3_FFFF_FFFF);

    // Same-cycle write and read to one index: write first, read returns new data.
    bus.wr_req = 1'b1; bus.wr_idx = 6'd9; bus.wr_data = 98'hAA; bus.wr_mask = '1;
    bus.rd_req = 1'b1; bus.rd_idx = 6'd9;
    @(negedge clk);
    chk("coll_wr_ack", bus.wr_ack, 1'b1);
    chk("coll_rd_ack0", bus.rd_ack, 1'b0);
    step();
    bus.wr_req = 1'b0;
    @(negedge clk);
    chk("coll_rd_ack1", bus.rd_ack, 1'b1);
    step();
    bus.rd_req = 1'b0;
    @(negedge clk);
    chk("coll_rd_vld", bus.rd_vld, 1'b1);
    chk("coll_rd_data", bus.rd_data, 98'hAA);
    step();

    // Flush restarted at cnt=30: one done pulse, 65 cycles after the restart request.
    bus.flush_req = 1'b1;
    step();
    bus.flush_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (!sram_cen && sram_a == 6'd30) got = 1'b1;
      else step();
    end
    if (!got) tmo("flush_cnt30");
    step();
    bus.flush_req = 1'b1;
    step();
    bus.flush_req = 1'b0;
    first = 0; dones = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.flush_done) begin
        dones++;
        if (first == 0) first = i + 1;
      end
      step();
    end
    chk("restart_done_cycle", first, 65);
    chk("restart_done_count", dones, 1);

    // Read requested during a flush is held off until idle and sees the zeroed entry.
    bus.flush_req = 1'b1;
    step();
    bus.flush_req = 1'b0;
    bus.rd_req = 1'b1; bus.rd_idx = 6'd9;
    wait_ack(1'b0, ok);
    chk("busy_at_rd_ack", bus.flush_busy, 1'b0);
    step();
    bus.rd_req = 1'b0;
    @(negedge clk);
    chk("flushed_rd_vld", bus.rd_vld, 1'b1);
    chk("flushed_rd_data", bus.rd_data, 98'h0);
    step();

    // Reset in the cycle a read return is pending: rd_vld is dropped.
    bus.rd_req = 1'b1; bus.rd_idx = 6'd3;
    wait_ack(1'b0, ok);
    step();
    bus.rd_req = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);
    chk("pend_rd_vld", bus.rd_vld, 1'b1);
    step();
    @(negedge clk);
    chk("rst_rd_vld", bus.rd_vld, 1'b0);
    step();
    rst_b = 1'b1;
    repeat (20) step();

    // Reset mid-flush with a read waiting: flush restarts at 0, read still no ack.
    bus.rd_req = 1'b1; bus.rd_idx = 6'd3;
    rst_b = 1'b0;
    step();
    step();
    rst_b = 1'b1;
    @(negedge clk);
    chk("rst_flush_a0", sram_a, 6'd0);
    chk("rst_flush_cen", sram_cen, 1'b0);
    chk("rst_flush_busy", bus.flush_busy, 1'b1);
    chk("rst_flush_rdack", bus.rd_ack, 1'b0);
    step();
    wait_ack(1'b0, ok);
    step();
    bus.rd_req = 1'b0;
    step();

`ifdef AQ_MMU_TLB_SRAM_PAR_EN
    // Parity: clean read reports no error, a flipped bit 3 does.
    do_write(6'd12, 98'h1234_5678, '0);
    do_read(6'd12, rdat, rerr);
    chk("par_clean_err", rerr, 1'b0);
    chk("par_clean_data", rdat, 98'h1234_5678);
    corrupt[3] = 1'b1;
    do_read(6'd12, rdat, rerr);
    chk("par_flip_err", rerr, 1'b1);
    corrupt = '0;
`endif

    // Randomized traffic; requesters hold until acked.
    wa = 1'b0; ra = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      wa = bus.wr_ack;
      ra = bus.rd_ack;
      step();
      if (!bus.wr_req || wa) begin
        if ($urandom_range(0, 2) == 0) begin
          bus.wr_req  = 1'b1;
          bus.wr_idx  = AW'($urandom_range(0, 7));
          bus.wr_data = rnd98();
          bus.wr_mask = ($urandom_range(0, 1) == 0) ? '1 : rnd98();
        end else begin
          bus.wr_req = 1'b0;
        end
      end
      if (!bus.rd_req || ra) begin
        bus.rd_req = ($urandom_range(0, 1) == 0);
        bus.rd_idx = AW'($urandom_range(0, 7));
      end
      bus.flush_req = ($urandom_range(0, 199) == 0);
    end
    bus.wr_req = 1'b0; bus.rd_req = 1'b0; bus.flush_req = 1'b0;
    repeat (80) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
